// File: rtl/seq_mul_if.sv
// rtl/seq_mul_if.sv - start/busy/done handshake bundle for seq_mul
// signed_op exists only when SEQ_MUL_SIGNED_EN is defined.
interface seq_mul_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     p;
`ifdef SEQ_MUL_SIGNED_EN
  logic                   signed_op;
`endif

  modport master (
`ifdef SEQ_MUL_SIGNED_EN
    output signed_op,
`endif
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
`ifdef SEQ_MUL_SIGNED_EN
    input  signed_op,
`endif
    input  start, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - sequential shift-add multiplier, one multiplier bit per clock
// Optional two's-complement operands under macro SEQ_MUL_SIGNED_EN.
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_mul_if.slave    bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     mq;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   p_reg;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod_next;
  logic [2*WIDTH-1:0]   p_load;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 busy_c;
  logic                 done_c;
  logic                 last_iter;

  // Extra top bit keeps the adder carry, which becomes the new acc MSB after the shift.
  assign sum       = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign prod_next = {sum, mq[WIDTH-1:1]};
  assign last_iter = (cnt == CNT_W'(1));

`ifdef SEQ_MUL_SIGNED_EN
  logic neg;
  logic neg_in;
  // Magnitude of the most negative value wraps to 2^(W-1), which is exact as unsigned.
  assign a_in   = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_in   = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign neg_in = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  assign p_load = neg ? -prod_next : prod_next;
`else
  assign a_in   = bus.a;
  assign b_in   = bus.b;
  assign p_load = prod_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
      p_reg <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= a_in;
            mq    <= b_in;
            acc   <= '0;
            cnt   <= CNT_W'(WIDTH);
`ifdef SEQ_MUL_SIGNED_EN
            neg   <= neg_in;
`endif
          end
        end
        RUN: begin
          {acc, mq} <= prod_next;
          cnt       <= cnt - CNT_W'(1);
          if (last_iter) begin
            p_reg <= p_load;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.p    = p_reg;
endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - scoreboard bench for seq_mul at WIDTH=8 and WIDTH=16
// Signed vectors run only when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_mul;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] p;
    int unsigned cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  seq_mul_if #(.WIDTH(8))  bus8 ();
  seq_mul_if #(.WIDTH(16)) bus16 ();

  seq_mul #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  seq_mul #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Monitors: pop an expectation on every done and check product and latency.
  logic prev_done8 = 1'b0;
  logic prev_done16 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus8.done) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got done with p=%h, required no done", bus8.p);
      end else begin
        e = q8.pop_front();
        chk("p8", {16'h0, bus8.p}, e.p);
        chk("latency8", cyc - e.cyc, 32'd8);
        chk("done8_width", {31'h0, prev_done8}, 32'd0);
      end
    end
    prev_done8 = bus8.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus16.done) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done16_unexpected: got done with p=%h, required no done", bus16.p);
      end else begin
        e = q16.pop_front();
        chk("p16", bus16.p, e.p);
        chk("latency16", cyc - e.cyc, 32'd16);
        chk("done16_width", {31'h0, prev_done16}, 32'd0);
      end
    end
    prev_done16 = bus16.done;
  end

  task automatic wait_idle8();
    int n = 0;
    while (bus8.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus8.busy) begin
      checks++;
      errors++;
      $display("FAIL idle8_timeout: got busy=1, required busy=0 within 100 cycles");
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] want);
    exp_t e;
    wait_idle8();
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    e.p = {16'h0, want};
    e.cyc = cyc + 1;
    q8.push_back(e);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a = 8'hxx;
    bus8.b = 8'hxx;
  endtask

  initial begin
    exp_t e;
    int n;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus16.start = 1'b0;
    bus16.a = '0;
    bus16.b = '0;
`ifdef SEQ_MUL_SIGNED_EN
    bus8.signed_op = 1'b0;
    bus16.signed_op = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy8", {31'h0, bus8.busy}, 32'd0);
    chk("rst_done8", {31'h0, bus8.done}, 32'd0);
    chk("rst_p8", {16'h0, bus8.p}, 32'd0);
    chk("rst_p16", bus16.p, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue8(8'd13, 8'd11, 16'h008F);
    issue8(8'd255, 8'd255, 16'hFE01);
    issue8(8'd0, 8'd200, 16'h0000);

    // start held high: accepts at offset 0 and at offset WIDTH+2 only.
    wait_idle8();
    for (int j = 0; j <= 10; j++) begin
      bus8.a = 8'(j + 3);
      bus8.b = 8'(2 * j + 1);
      bus8.start = 1'b1;
      if (j == 0) begin
        e.p = 32'h0003;
        e.cyc = cyc + 1;
        q8.push_back(e);
      end
      if (j == 10) begin
        e.p = 32'h0111;
        e.cyc = cyc + 1;
        q8.push_back(e);
      end
      @(negedge clk);
    end
    bus8.start = 1'b0;

    // Abort an operation 4 cycles into RUN; no done may follow.
    wait_idle8();
    bus8.a = 8'd9;
    bus8.b = 8'd9;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy8", {31'h0, bus8.busy}, 32'd0);
    chk("abort_done8", {31'h0, bus8.done}, 32'd0);
    chk("abort_p8", {16'h0, bus8.p}, 32'd0);
    repeat (12) @(negedge clk);
    issue8(8'd7, 8'd6, 16'd42);

`ifdef SEQ_MUL_SIGNED_EN
    bus8.signed_op = 1'b1;
    issue8(8'hFD, 8'd5, 16'hFFF1);
    issue8(8'h80, 8'h80, 16'h4000);
    issue8(8'h80, 8'h01, 16'hFF80);
    wait_idle8();
    bus8.signed_op = 1'b0;
    issue8(8'hFD, 8'd5, 16'h04F1);
`endif

    bus16.a = 16'hFFFF;
    bus16.b = 16'h0002;
    bus16.start = 1'b1;
    e.p = 32'h0001FFFE;
    e.cyc = cyc + 1;
    q16.push_back(e);
    @(negedge clk);
    bus16.start = 1'b0;

    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q8.size() != 0 || q16.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0", q8.size(), q16.size());
    end
    repeat (20) @(negedge clk);
    chk("hold_p8", {16'h0, bus8.p}, 32'h0000_0000 | (`ifdef SEQ_MUL_SIGNED_EN 32'h04F1 `else 32'd42 `endif));
    chk("hold_p16", bus16.p, 32'h0001FFFE);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
